// File: rtl/abc_serial_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | abc_serial_rx : UART-style receiver recovering {A,B,C} from one wire;   |
// | optional even parity via ABC_RX_PARITY_EN.          Rev 1.0             |
// +------------------------------------------------------------------------+
module abc_serial_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [2:0] d_out,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       d_valid,
  output logic       frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef ABC_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      idx_q;
  logic [2:0]      shift_q;
  logic [2:0]      d_q;
  logic            valid_q;
  logic            err_q;
`ifdef ABC_RX_PARITY_EN
  logic            par_bad_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      d_q       <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef ABC_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          // A start bit that is high again at mid-bit is a glitch, dropped silently.
          if (cnt_q == c_CNT_HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_q                 <= '0;
            shift_q[2'd2 - idx_q] <= rx_s_q;
            idx_q                 <= idx_q + 2'd1;
            if (idx_q == 2'd2) begin
`ifdef ABC_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
`ifdef ABC_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_q     <= '0;
            par_bad_q <= ^{shift_q, rx_s_q};
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
`ifdef ABC_RX_PARITY_EN
            if (rx_s_q && !par_bad_q) begin
`else
            if (rx_s_q) begin
`endif
              d_q     <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign d_out     = d_q;
  assign a_out     = d_q[2];
  assign b_out     = d_q[1];
  assign c_out     = d_q[0];
  assign d_valid   = valid_q;
  assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_abc_serial_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_abc_serial_rx : self-checking bench for abc_serial_rx                |
// | (honours ABC_RX_PARITY_EN).                          Rev 1.0            |
// +------------------------------------------------------------------------+
module tb_abc_serial_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
`ifdef ABC_RX_PARITY_EN
  localparam int NBITS = 6;
  localparam int LAT   = 25;
`else
  localparam int NBITS = 5;
  localparam int LAT   = 21;
`endif
  // Pin-sample offsets from the first edge that sees the line low.
  localparam int STOP_OFS   = HALF + (NBITS - 1) * CPB;
  localparam int DONE_OFS   = STOP_OFS + 2;
  localparam int GLITCH_OFS = HALF + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [2:0] d_out;
  logic       a_out, b_out, c_out, d_valid, frame_err;

  abc_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .d_out     (d_out),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_valid   (d_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit pin_hist [0:16383];

  // Frame-level model: decode from the pin sample history at bit centres.
  logic [2:0] m_d     = 3'b000;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;
  bit         m_live  = 1'b0;
  bit         pend    = 1'b0;
  int         pend_f  = 0;
  int         next_ok = 0;
  logic [2:0] m_bits;
  bit         m_ok;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < 16384) pin_hist[cyc] = rx_in;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_live  = 1'b1;
      pend    = 1'b0;
      next_ok = cyc + 1;
      m_d     = 3'b000;
    end else if (m_live) begin
      if (pend && cyc == pend_f + GLITCH_OFS && pin_hist[pend_f + HALF]) begin
        pend    = 1'b0;
        next_ok = cyc - 1;
      end else if (pend && cyc == pend_f + DONE_OFS) begin
        m_bits = {pin_hist[pend_f + HALF + CPB], pin_hist[pend_f + HALF + 2*CPB],
                  pin_hist[pend_f + HALF + 3*CPB]};
        m_ok = pin_hist[pend_f + STOP_OFS];
`ifdef ABC_RX_PARITY_EN
        if ((^m_bits) ^ pin_hist[pend_f + HALF + 4*CPB]) m_ok = 1'b0;
`endif
        if (m_ok) begin
          m_valid = 1'b1;
          m_d     = m_bits;
        end else begin
          m_err = 1'b1;
        end
        pend    = 1'b0;
        next_ok = cyc - 1;
      end
      if (!pend && cyc - 2 >= next_ok && !pin_hist[cyc - 2]) begin
        pend   = 1'b1;
        pend_f = cyc - 2;
      end
    end
  end

  int         vc = 0;
  int         ec = 0;
  int         v_cyc [0:63];
  logic [2:0] v_d   [0:63];
  int         e_cyc [0:63];

  always @(negedge clk) begin
    if (m_live) begin
      n_cmp = n_cmp + 1;
      if ({d_out, a_out, b_out, c_out, d_valid, frame_err} !== {m_d, m_d, m_valid, m_err}) begin
        n_bad = n_bad + 1;
        $display("FAIL model cyc=%0d: got d=%b abc=%b%b%b v=%b e=%b, want d=%b v=%b e=%b",
                 cyc, d_out, a_out, b_out, c_out, d_valid, frame_err, m_d, m_valid, m_err);
      end
      if (d_valid === 1'b1 && vc < 64) begin v_cyc[vc] = cyc; v_d[vc] = d_out; vc = vc + 1; end
      if (frame_err === 1'b1 && ec < 64) begin e_cyc[ec] = cyc; ec = ec + 1; end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] abc, input logic stop, input logic flip_par,
                            output int t0);
    t0 = cyc;
    send_bit(1'b0);
    send_bit(abc[2]);
    send_bit(abc[1]);
    send_bit(abc[0]);
`ifdef ABC_RX_PARITY_EN
    send_bit((^abc) ^ flip_par);
`else
    if (flip_par) rx_in = abc[0];
`endif
    send_bit(stop);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2, k, base_v, base_e;
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_d_out", 32'(d_out), 32'd0);
    check("reset_valid", 32'(d_valid), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    idle(20);
    check("idle_no_pulses", 32'(vc + ec), 32'd0);

    // Single good frame A=1 B=0 C=1.
    send_frame(3'b101, 1'b1, 1'b0, t0);
    idle(6);
    check("single_count", 32'(vc), 32'd1);
    check("single_latency", 32'(v_cyc[0] - t0), 32'(LAT));
    check("single_d", 32'(v_d[0]), 32'b101);
    check("single_abc", 32'({a_out, b_out, c_out}), 32'b101);

    // Back-to-back frames with no idle gap.
    send_frame(3'b011, 1'b1, 1'b0, t1);
    send_frame(3'b110, 1'b1, 1'b0, t2);
    idle(6);
    check("b2b_count", 32'(vc), 32'd3);
    check("b2b_first_time", 32'(v_cyc[1] - t1), 32'(LAT));
    check("b2b_first_d", 32'(v_d[1]), 32'b011);
    check("b2b_second_time", 32'(v_cyc[2] - t2), 32'(LAT));
    check("b2b_second_d", 32'(v_d[2]), 32'b110);

    // One-cycle start glitch.
    rx_in = 1'b0;
    @(negedge clk);
    idle(30);
    check("glitch_pulses", 32'(vc + ec), 32'd3);

    // Bad stop bit.
    send_frame(3'b010, 1'b0, 1'b0, t0);
    idle(10);
    check("stop_err_count", 32'(ec), 32'd1);
    check("stop_err_time", 32'(e_cyc[0] - t0), 32'(LAT));
    check("stop_err_hold", 32'(d_out), 32'b110);
    check("stop_err_no_valid", 32'(vc), 32'd3);

    // Reset during bit B.
    send_bit(1'b0);
    send_bit(1'b1);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(30);
    check("rst_mid_pulses", 32'(vc + ec), 32'd4);
    check("rst_mid_d", 32'(d_out), 32'd0);
    send_frame(3'b111, 1'b1, 1'b0, t0);
    idle(6);
    check("after_rst_time", 32'(v_cyc[3] - t0), 32'(LAT));
    check("after_rst_d", 32'(v_d[3]), 32'b111);

    // Line stuck low: repeated framing errors, no lock-up.
    base_v = vc;
    base_e = ec;
    rx_in = 1'b0;
    k = 0;
    while (ec < base_e + 3 && k < 200) begin
      @(negedge clk);
      #1;
      k = k + 1;
    end
    rx_in = 1'b1;
    check("stuck_err_count", 32'(ec - base_e), 32'd3);
    check("stuck_no_valid", 32'(vc - base_v), 32'd0);
    check("stuck_hold", 32'(d_out), 32'b111);
    idle(30);
    check("stuck_recover_quiet", 32'(vc + ec), 32'(base_v + base_e + 3));

`ifdef ABC_RX_PARITY_EN
    send_frame(3'b101, 1'b1, 1'b0, t0);
    idle(6);
    check("par_good_time", 32'(v_cyc[vc - 1] - t0), 32'(LAT));
    check("par_good_d", 32'(d_out), 32'b101);
    base_e = ec;
    send_frame(3'b101, 1'b1, 1'b1, t0);
    idle(6);
    check("par_bad_err", 32'(ec - base_e), 32'd1);
    check("par_bad_time", 32'(e_cyc[ec - 1] - t0), 32'(LAT));
    check("par_bad_hold", 32'(d_out), 32'b101);
`endif

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
